// File: rtl/core6502_pkg.sv
// core6502_pkg
// Shared constants for the 6502 core and its interrupt-side helpers.
//   VEC_NMI / VEC_RES / VEC_IRQ : low-byte addresses of the hardware vectors
//   nmi_state_t                 : encoding of the NMI pulse generator states
package core6502_pkg;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  typedef enum logic [1:0] {
    N_IDLE = 2'd0,
    N_LOW  = 2'd1,
    N_GAP  = 2'd2
  } nmi_state_t;

endpackage

// File: rtl/int_nmi_pulser.sv
// int_nmi_pulser
// Turns accepted NMI requests into n_NMI low pulses with a guaranteed
// minimum width, a timeout, and a mandatory high gap so the core always
// sees a fresh falling edge. Holds a one-deep request queue.
//
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   nmi_accept : request pulse already qualified by the enable
//   nmi_hit    : NMI vector fetch seen on the bus this cycle
//   n_nmi      : registered active-low NMI to the core
//   nmi_ack    : registered one-cycle pulse when a pulse ends by acknowledge
//   nmi_lost   : sticky, a request arrived while the queue was full
//
// state  | meaning
// N_IDLE | n_NMI high, waiting for a request
// N_LOW  | n_NMI low, counting toward min width / timeout
// N_GAP  | n_NMI high, enforcing the recovery gap before the next pulse
module int_nmi_pulser
  import core6502_pkg::*;
#(
  parameter int NMI_MIN_LOW = 4,
  parameter int NMI_MAX_LOW = 64,
  parameter int NMI_GAP     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic nmi_accept,
  input  logic nmi_hit,
  output logic n_nmi,
  output logic nmi_ack,
  output logic nmi_lost
);

  localparam int CNT_MAX = (NMI_MAX_LOW > NMI_GAP) ? NMI_MAX_LOW : NMI_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(NMI_MIN_LOW);
  localparam logic [CNT_W-1:0] MAX_LOW_C = CNT_W'(NMI_MAX_LOW);
  localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(NMI_GAP);

  localparam logic [1:0] ST_IDLE = N_IDLE;
  localparam logic [1:0] ST_LOW  = N_LOW;
  localparam logic [1:0] ST_GAP  = N_GAP;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             ack_seen, ack_seen_nxt;
  logic             queued, queued_nxt;
  logic             lost, lost_nxt;
  logic             ack_pulse;

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ack_seen_nxt = ack_seen;
    queued_nxt   = queued;
    lost_nxt     = lost;
    ack_pulse    = 1'b0;
    case (state)
      ST_IDLE: begin
        ack_seen_nxt = 1'b0;
        if (nmi_accept) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end
      end
      ST_LOW: begin
        cnt_nxt = cnt_inc;
        if (nmi_hit) ack_seen_nxt = 1'b1;
        if (nmi_accept) begin
          if (queued) lost_nxt = 1'b1;
          else        queued_nxt = 1'b1;
        end
        // An early acknowledge is held until the minimum width is met.
        if ((nmi_hit || ack_seen) && cnt_inc >= MIN_LOW_C) begin
          state_nxt    = ST_GAP;
          cnt_nxt      = '0;
          ack_seen_nxt = 1'b0;
          ack_pulse    = 1'b1;
        end else if (cnt_inc == MAX_LOW_C) begin
          state_nxt    = ST_GAP;
          cnt_nxt      = '0;
          ack_seen_nxt = 1'b0;
        end
      end
      ST_GAP: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == GAP_C) begin
          cnt_nxt = '0;
          if (queued) begin
            state_nxt  = ST_LOW;
            queued_nxt = 1'b0;
            if (nmi_accept) lost_nxt = 1'b1;
          end else if (nmi_accept) begin
            // Request coinciding with the gap end starts the next pulse directly.
            state_nxt = ST_LOW;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (nmi_accept) begin
          if (queued) lost_nxt = 1'b1;
          else        queued_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ack_seen <= 1'b0;
      queued   <= 1'b0;
      lost     <= 1'b0;
      n_nmi    <= 1'b1;
      nmi_ack  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ack_seen <= ack_seen_nxt;
      queued   <= queued_nxt;
      lost     <= lost_nxt;
      n_nmi    <= (state_nxt != ST_LOW);
      nmi_ack  <= ack_pulse;
    end
  end

  assign nmi_lost = lost;

endmodule

// File: rtl/int_request_gen.sv
// int_request_gen
// Interrupt-source side of the 6502 /NMI and /IRQ interface. Collects
// peripheral events, drives n_IRQ (level) and n_NMI (pulse), and detects
// acknowledge by snooping vector fetches.
//
// Ports:
//   CLK, RES       : clock, synchronous active-high reset
//   irq_set        : per-source event pulses
//   irq_clr        : write-1-to-clear strobes for pending bits
//   irq_mask       : per-source enable onto n_IRQ
//   nmi_req/nmi_en : NMI request pulse and its enable
//   bus_valid/ADDR/RnW : CPU bus snoop
//   n_NMI, n_IRQ   : active-low interrupt lines to the core
//   irq_pending    : pending flags
//   nmi_ack/irq_ack: one-cycle acknowledge pulses
//   nmi_lost       : sticky dropped-request flag
module int_request_gen
  import core6502_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int NMI_MIN_LOW = 4,
  parameter int NMI_MAX_LOW = 64,
  parameter int NMI_GAP     = 4
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [NUM_IRQ-1:0] irq_set,
  input  logic [NUM_IRQ-1:0] irq_clr,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               nmi_req,
  input  logic               nmi_en,
  input  logic               bus_valid,
  input  logic [15:0]        ADDR,
  input  logic               RnW,
  output logic               n_NMI,
  output logic               n_IRQ,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               nmi_ack,
  output logic               irq_ack,
  output logic               nmi_lost
);

  logic               nmi_hit, irq_hit;
  logic [NUM_IRQ-1:0] pending, pending_nxt;
  logic               n_irq_q, irq_ack_q;

  assign nmi_hit = bus_valid & RnW & (ADDR == VEC_NMI);
  assign irq_hit = bus_valid & RnW & (ADDR == VEC_IRQ);

  // Set wins over clear so a coincident event is never dropped.
  assign pending_nxt = irq_set | (pending & ~irq_clr);

  always_ff @(posedge CLK) begin
    if (RES) begin
      pending   <= '0;
      n_irq_q   <= 1'b1;
      irq_ack_q <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      n_irq_q   <= ~|(pending_nxt & irq_mask);
      // Only a vector fetch made while the line was actually asserted counts.
      irq_ack_q <= irq_hit & ~n_irq_q;
    end
  end

  int_nmi_pulser #(
    .NMI_MIN_LOW (NMI_MIN_LOW),
    .NMI_MAX_LOW (NMI_MAX_LOW),
    .NMI_GAP     (NMI_GAP)
  ) u_nmi (
    .clk        (CLK),
    .rst        (RES),
    .nmi_accept (nmi_req & nmi_en),
    .nmi_hit    (nmi_hit),
    .n_nmi      (n_NMI),
    .nmi_ack    (nmi_ack),
    .nmi_lost   (nmi_lost)
  );

  assign irq_pending = pending;
  assign n_IRQ       = n_irq_q;
  assign irq_ack     = irq_ack_q;

endmodule

// File: tb/tb_int_request_gen.sv
module tb_int_request_gen;

  logic        CLK = 1'b0;
  logic        RES;
  logic [3:0]  irq_set, irq_clr, irq_mask;
  logic        nmi_req, nmi_en, bus_valid, RnW;
  logic [15:0] ADDR;
  logic        n_NMI, n_IRQ, nmi_ack, irq_ack, nmi_lost;
  logic [3:0]  irq_pending;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  int_request_gen dut (
    .CLK(CLK), .RES(RES), .irq_set(irq_set), .irq_clr(irq_clr),
    .irq_mask(irq_mask), .nmi_req(nmi_req), .nmi_en(nmi_en),
    .bus_valid(bus_valid), .ADDR(ADDR), .RnW(RnW), .n_NMI(n_NMI),
    .n_IRQ(n_IRQ), .irq_pending(irq_pending), .nmi_ack(nmi_ack),
    .irq_ack(irq_ack), .nmi_lost(nmi_lost)
  );

  typedef struct {
    logic [3:0]  set;
    logic [3:0]  clr;
    logic [3:0]  mask;
    logic        valid;
    logic        rnw;
    logic [15:0] addr;
    logic [3:0]  exp_pend;
    logic        exp_n_irq;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic v, input logic [15:0] a);
    bus_valid = v;
    ADDR      = a;
    RnW       = 1'b1;
  endtask

  int low_cnt;
  int ack_cnt;

  initial begin
    RES = 1'b1; irq_set = 4'hF; irq_clr = '0; irq_mask = 4'hF;
    nmi_req = 1'b1; nmi_en = 1'b1; bus_valid = 1'b0; ADDR = '0; RnW = 1'b1;

    // set, clr, mask, valid, rnw, addr, exp pending, exp n_IRQ, exp irq_ack
    vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 16'h0000, 4'b0100, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b1, 16'h0000, 4'b0010, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0};
    vecs[4]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'hFFFE, 4'b0001, 1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'h0000, 4'b0001, 1'b0, 1'b0};
    vecs[6]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 16'hFFFE, 4'b0001, 1'b0, 1'b1};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 16'hFFFE, 4'b0001, 1'b0, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'hFFFE, 4'b0001, 1'b0, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 16'hFFFC, 4'b0001, 1'b0, 1'b0};
    vecs[10] = '{4'b1000, 4'b0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 4'b1000, 1'b0, 1'b0};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'h0000, 4'b1000, 1'b1, 1'b0};
    vecs[12] = '{4'b0000, 4'b1000, 4'b1111, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0};

    // Reset held two cycles with events and an NMI request present.
    tick(); tick();
    chk("rst_pending", irq_pending, 4'h0);
    chk("rst_n_irq", n_IRQ, 1'b1);
    chk("rst_n_nmi", n_NMI, 1'b1);
    chk("rst_lost", nmi_lost, 1'b0);
    RES = 1'b0; irq_set = '0; irq_mask = '0; nmi_req = 1'b0;
    tick();
    chk("post_rst_n_nmi", n_NMI, 1'b1);

    // IRQ table
    foreach (vecs[i]) begin
      irq_set = vecs[i].set; irq_clr = vecs[i].clr; irq_mask = vecs[i].mask;
      bus_valid = vecs[i].valid; RnW = vecs[i].rnw; ADDR = vecs[i].addr;
      tick();
      chk($sformatf("vec%0d_pending", i), irq_pending, vecs[i].exp_pend);
      chk($sformatf("vec%0d_n_irq", i), n_IRQ, vecs[i].exp_n_irq);
      chk($sformatf("vec%0d_irq_ack", i), irq_ack, vecs[i].exp_ack);
      chk($sformatf("vec%0d_n_nmi", i), n_NMI, 1'b1);
    end
    irq_set = '0; irq_clr = '0; irq_mask = '0; bus(1'b0, 16'h0000);
    tick();

    // NMI with early acknowledge: req in cycle 10, hit in cycle 13.
    nmi_req = 1'b1;                                  // cycle 10
    tick(); nmi_req = 1'b0;                          // cycle 11
    chk("nmi1_low_t11", n_NMI, 1'b0);
    tick();                                          // 12
    tick(); bus(1'b1, 16'hFFFA);                     // 13
    chk("nmi1_low_t13", n_NMI, 1'b0);
    tick(); bus(1'b0, 16'h0000);                     // 14
    chk("nmi1_low_t14", n_NMI, 1'b0);
    chk("nmi1_noack_t14", nmi_ack, 1'b0);
    tick();                                          // 15
    chk("nmi1_high_t15", n_NMI, 1'b1);
    chk("nmi1_ack_t15", nmi_ack, 1'b1);
    tick();                                          // 16
    chk("nmi1_ack_pulse_t16", nmi_ack, 1'b0);
    tick(); tick();                                  // 18
    chk("nmi1_high_t18", n_NMI, 1'b1);
    tick(); nmi_req = 1'b1;                          // 19: must be idle
    chk("nmi1_high_t19", n_NMI, 1'b1);
    tick(); nmi_req = 1'b0; bus(1'b1, 16'hFFFA);     // 20: immediate restart
    chk("nmi2_low_t20", n_NMI, 1'b0);
    tick(); bus(1'b0, 16'h0000);                     // 21
    tick(); tick();                                  // 23
    chk("nmi2_low_t23", n_NMI, 1'b0);
    tick();                                          // 24
    chk("nmi2_high_t24", n_NMI, 1'b1);
    chk("nmi2_ack_t24", nmi_ack, 1'b1);
    repeat (4) tick();

    // Timeout: no vector fetch.
    nmi_req = 1'b1;
    tick(); nmi_req = 1'b0;
    low_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (nmi_ack) ack_cnt++;
      if (n_NMI == 1'b0) low_cnt++;
      else break;
      tick();
    end
    chk("timeout_low_cycles", low_cnt, 64);
    chk("timeout_no_ack", ack_cnt, 0);
    repeat (4) tick();

    // Three requests at t=10, 12, 14.
    nmi_req = 1'b1;                                  // 10
    tick(); nmi_req = 1'b0;                          // 11
    chk("q_lost_t11", nmi_lost, 1'b0);
    tick(); nmi_req = 1'b1;                          // 12
    tick(); nmi_req = 1'b0; bus(1'b1, 16'hFFFA);     // 13
    chk("q_lost_t13", nmi_lost, 1'b0);
    tick(); bus(1'b0, 16'h0000); nmi_req = 1'b1;     // 14
    chk("q_lost_t14", nmi_lost, 1'b0);
    tick(); nmi_req = 1'b0;                          // 15
    chk("q_lost_t15", nmi_lost, 1'b1);
    chk("q_ack_t15", nmi_ack, 1'b1);
    chk("q_high_t15", n_NMI, 1'b1);
    tick(); tick(); tick();                          // 18
    chk("q_high_t18", n_NMI, 1'b1);
    tick(); bus(1'b1, 16'hFFFA);                     // 19: queued pulse
    chk("q_low_t19", n_NMI, 1'b0);
    tick(); bus(1'b0, 16'h0000);                     // 20
    tick(); tick(); tick();                          // 23
    chk("q_high_t23", n_NMI, 1'b1);
    chk("q_ack_t23", nmi_ack, 1'b1);
    repeat (5) tick();                               // 28: queue empty
    chk("q_no_third_pulse", n_NMI, 1'b1);
    chk("q_lost_sticky", nmi_lost, 1'b1);

    // Reset during N_LOW with a request queued and an IRQ pending.
    irq_set = 4'b0001; irq_mask = 4'b0001; nmi_req = 1'b1;
    tick(); irq_set = '0;                            // low, queue next
    chk("r_low", n_NMI, 1'b0);
    tick(); nmi_req = 1'b0;
    RES = 1'b1;
    tick(); RES = 1'b0;
    chk("r_n_nmi_released", n_NMI, 1'b1);
    chk("r_lost_cleared", nmi_lost, 1'b0);
    chk("r_pending_cleared", irq_pending, 4'h0);
    chk("r_n_irq", n_IRQ, 1'b1);
    low_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (n_NMI == 1'b0) low_cnt++;
    end
    chk("r_queue_discarded", low_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
